// File: rtl/local_inject_queue_if.sv
// ---------------------------------------------------------------------------
// local_inject_queue_if
//
// Purpose: bundles the PE-side handshake and the router-side inject signals
// of local_inject_queue into one interface.
//
// Signals:
//   pe_valid         PE offers a flit
//   pe_flit          PE flit payload (FLIT_W)
//   pe_ready         queue accepts a flit this cycle
//   localInjectGrant one-hot or zero free-channel grant (NUM_CHANNEL)
//   inject_req       head flit present
//   injectValidOut   registered one-hot channel receiving the flit
//   injectFlitOut    registered injected flit (FLIT_W)
//   starve_flag      head flit waited too long for a free channel
//
// Modports:
//   master - PE / grant stage side (drives pe_valid, pe_flit, localInjectGrant)
//   slave  - the queue itself
// ---------------------------------------------------------------------------
interface local_inject_queue_if #(
    parameter int NUM_CHANNEL = 5,
    parameter int FLIT_W      = 64
);
    logic                   pe_valid;
    logic [FLIT_W-1:0]      pe_flit;
    logic                   pe_ready;
    logic [NUM_CHANNEL-1:0] localInjectGrant;
    logic                   inject_req;
    logic [NUM_CHANNEL-1:0] injectValidOut;
    logic [FLIT_W-1:0]      injectFlitOut;
    logic                   starve_flag;

    modport master (
        output pe_valid,
        output pe_flit,
        output localInjectGrant,
        input  pe_ready,
        input  inject_req,
        input  injectValidOut,
        input  injectFlitOut,
        input  starve_flag
    );

    modport slave (
        input  pe_valid,
        input  pe_flit,
        input  localInjectGrant,
        output pe_ready,
        output inject_req,
        output injectValidOut,
        output injectFlitOut,
        output starve_flag
    );
endinterface

// File: rtl/local_inject_queue.sv
// ---------------------------------------------------------------------------
// local_inject_queue
//
// Purpose: buffers flits from the local processing element and injects the
// head flit into the router channel pipeline whenever the inject-grant stage
// offers a free channel. The granted channel's slot is driven one cycle after
// the grant is sampled, aligned with the channel pipeline register.
//
// Ports:
//   clk    in   clock, all state on rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    local_inject_queue_if.slave
//          pe_valid/pe_flit/pe_ready   PE push handshake
//          localInjectGrant            one-hot-or-zero channel grant
//          inject_req                  queue non-empty
//          injectValidOut/injectFlitOut registered inject slot
//          starve_flag                 head waited >= STARVE_TH cycles
//
// Parameters: NUM_CHANNEL, FLIT_W, DEPTH (power of two, >= 2),
//             STARVE_TH (1..255)
//
// Optional feature macro: LOCAL_INJECT_STARVE_EN
//   defined   - 8-bit saturating starvation counter drives starve_flag
//   undefined - no counter is built, starve_flag is tied low
// ---------------------------------------------------------------------------
module local_inject_queue #(
    parameter int NUM_CHANNEL = 5,
    parameter int FLIT_W      = 64,
    parameter int DEPTH       = 4,
    parameter int STARVE_TH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    local_inject_queue_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    // Storage and pointers; the extra MSB of each pointer is the wrap bit.
    logic [FLIT_W-1:0]      mem [DEPTH];
    logic [PTR_W:0]         wrPtr;
    logic [PTR_W:0]         rdPtr;

    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   anyGrant;
    logic [NUM_CHANNEL-1:0] grantLowest;

    logic [NUM_CHANNEL-1:0] injectValidReg;
    logic [FLIT_W-1:0]      injectFlitReg;

    // Status flags come straight from the registered pointers so that
    // pe_ready never depends on a pop happening in the same cycle.
    always_comb begin
        empty = (wrPtr == rdPtr);
        full  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    end

    // Handshake decode. A multi-hot grant is illegal upstream; isolating the
    // lowest set bit keeps the injected slot strictly one-hot anyway.
    always_comb begin
        anyGrant    = |bus.localInjectGrant;
        grantLowest = bus.localInjectGrant &
                      (~bus.localInjectGrant + NUM_CHANNEL'(1));
        push        = bus.pe_valid && !full;
        pop         = !empty && anyGrant;
    end

    assign bus.pe_ready   = !full;
    assign bus.inject_req = !empty;

    // Pointer registers. Both may move in the same cycle, which keeps
    // occupancy unchanged on simultaneous push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
        end
    end

    // Flit storage has no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[PTR_W-1:0]] <= bus.pe_flit;
        end
    end

    // Inject slot register. The valid vector is a one-cycle pulse per pop
    // while the flit payload holds its last value between pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            injectValidReg <= '0;
            injectFlitReg  <= '0;
        end else if (pop) begin
            injectValidReg <= grantLowest;
            injectFlitReg  <= mem[rdPtr[PTR_W-1:0]];
        end else begin
            injectValidReg <= '0;
        end
    end

    assign bus.injectValidOut = injectValidReg;
    assign bus.injectFlitOut  = injectFlitReg;

`ifdef LOCAL_INJECT_STARVE_EN
    logic [7:0] starveCnt;
    logic [7:0] starveCntNext;
    logic       starveFlagReg;

    // Counts cycles the head flit sits waiting without any free channel.
    // Clearing on pop restarts the count for the next head flit.
    always_comb begin
        starveCntNext = starveCnt;
        if (empty || pop) begin
            starveCntNext = '0;
        end else if (starveCnt != 8'hFF) begin
            starveCntNext = starveCnt + 8'd1;
        end
    end

    // The flag is registered from the next count so it lines up with the
    // counter value it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCnt     <= '0;
            starveFlagReg <= 1'b0;
        end else begin
            starveCnt     <= starveCntNext;
            starveFlagReg <= (starveCntNext >= 8'(STARVE_TH));
        end
    end

    assign bus.starve_flag = starveFlagReg;
`else
    assign bus.starve_flag = 1'b0;
`endif

endmodule

// File: tb/tb_local_inject_queue.sv
// ---------------------------------------------------------------------------
// tb_local_inject_queue
//
// Self-checking bench for local_inject_queue. A queue-based reference model
// tracks the expected contents and inject slot; a negedge compare process
// checks every DUT output against it, and directed scenarios pin literal
// values.
// ---------------------------------------------------------------------------
module tb_local_inject_queue;

    localparam int NUM_CH    = 5;
    localparam int FW        = 64;
    localparam int DEPTH     = 4;
    localparam int STARVE_TH = 16;

    logic clk;
    logic rst_n;
    bit   checkEnable;

    int compareCount;
    int mismatchCount;

    local_inject_queue_if #(.NUM_CHANNEL(NUM_CH), .FLIT_W(FW)) bus ();

    local_inject_queue #(
        .NUM_CHANNEL (NUM_CH),
        .FLIT_W      (FW),
        .DEPTH       (DEPTH),
        .STARVE_TH   (STARVE_TH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [FW-1:0]     modelQ [$];
    logic [NUM_CH-1:0] expValid;
    logic [FW-1:0]     expFlit;
    int                waitCycles;

    function automatic logic [NUM_CH-1:0] lowestGrant(input logic [NUM_CH-1:0] g);
        for (int i = 0; i < NUM_CH; i++) begin
            if (g[i]) return NUM_CH'(1) << i;
        end
        return '0;
    endfunction

    // Model advances on every rising edge from the inputs that were held
    // across it; reset wipes it asynchronously like the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelQ.delete();
            expValid   = '0;
            expFlit    = '0;
            waitCycles = 0;
        end else begin
            bit canPush;
            bit doPop;
            canPush = bus.pe_valid && (modelQ.size() < DEPTH);
            doPop   = (modelQ.size() > 0) && (bus.localInjectGrant != '0);
            if (modelQ.size() == 0 || doPop) waitCycles = 0;
            else if (waitCycles < 255)       waitCycles = waitCycles + 1;
            if (doPop) begin
                expValid = lowestGrant(bus.localInjectGrant);
                expFlit  = modelQ.pop_front();
            end else begin
                expValid = '0;
            end
            if (canPush) modelQ.push_back(bus.pe_flit);
        end
    end

    task automatic checkOutput(input string name, input logic [FW-1:0] actual,
                               input logic [FW-1:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then return just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [FW-1:0] f,
                                 input logic [NUM_CH-1:0] g);
        bus.pe_valid         = v;
        bus.pe_flit          = f;
        bus.localInjectGrant = g;
        @(posedge clk);
        #1;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEnable) begin
            logic expStarve;
`ifdef LOCAL_INJECT_STARVE_EN
            expStarve = (waitCycles >= STARVE_TH);
`else
            expStarve = 1'b0;
`endif
            checkOutput("pe_ready",       FW'(bus.pe_ready),       FW'(modelQ.size() < DEPTH));
            checkOutput("inject_req",     FW'(bus.inject_req),     FW'(modelQ.size() > 0));
            checkOutput("injectValidOut", FW'(bus.injectValidOut), FW'(expValid));
            checkOutput("injectFlitOut",  bus.injectFlitOut,       expFlit);
            checkOutput("starve_flag",    FW'(bus.starve_flag),    FW'(expStarve));
        end
    end

    initial begin
        logic [FW-1:0] pushed [4];
        compareCount  = 0;
        mismatchCount = 0;
        checkEnable   = 1'b0;
        rst_n         = 1'b0;
        bus.pe_valid         = 1'b0;
        bus.pe_flit          = '0;
        bus.localInjectGrant = '0;

        #1;
        checkOutput("reset pe_ready",    FW'(bus.pe_ready),       FW'(1));
        checkOutput("reset inject_req",  FW'(bus.inject_req),     FW'(0));
        checkOutput("reset validOut",    FW'(bus.injectValidOut), FW'(0));
        checkOutput("reset flitOut",     bus.injectFlitOut,       FW'(0));
        checkOutput("reset starve_flag", FW'(bus.starve_flag),    FW'(0));

        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        checkEnable = 1'b1;
        $display("[TB] reset released");

        // Single flit: push, grant channel 2, flit appears the next cycle.
        applyStimulus(1'b1, 64'hA5, 5'b00000);
        checkOutput("single inject_req up", FW'(bus.inject_req), FW'(1));
        applyStimulus(1'b0, '0, 5'b00100);
        checkOutput("single validOut", FW'(bus.injectValidOut), FW'(5'b00100));
        checkOutput("single flitOut",  bus.injectFlitOut, 64'hA5);
        checkOutput("model flit pin",  expFlit, 64'hA5);
        checkOutput("single inject_req down", FW'(bus.inject_req), FW'(0));
        applyStimulus(1'b0, '0, 5'b00000);
        checkOutput("single validOut clear", FW'(bus.injectValidOut), FW'(0));
        checkOutput("single flit hold", bus.injectFlitOut, 64'hA5);

        // Fill to full, refuse a fifth flit, drain in push order.
        for (int i = 0; i < 4; i++) begin
            pushed[i] = 64'h1111 * FW'(i + 1);
            applyStimulus(1'b1, pushed[i], 5'b00000);
        end
        checkOutput("full pe_ready", FW'(bus.pe_ready), FW'(0));
        applyStimulus(1'b1, 64'hDEAD, 5'b00000);
        checkOutput("full still refused", FW'(bus.pe_ready), FW'(0));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 5'b00001);
            checkOutput("drain order", bus.injectFlitOut, pushed[i]);
        end
        checkOutput("drained inject_req", FW'(bus.inject_req), FW'(0));

        // Grant while empty is ignored.
        applyStimulus(1'b0, '0, 5'b00001);
        checkOutput("empty grant validOut", FW'(bus.injectValidOut), FW'(0));
        checkOutput("empty grant flit hold", bus.injectFlitOut, pushed[3]);

        // Steady push/pop at occupancy 2 across pointer wrap.
        applyStimulus(1'b1, 64'h100, 5'b00000);
        applyStimulus(1'b1, 64'h101, 5'b00000);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 64'h102 + FW'(i), 5'b01000);
            checkOutput("steady order", bus.injectFlitOut, 64'h100 + FW'(i));
            checkOutput("steady occupancy", FW'(modelQ.size()), FW'(2));
        end
        applyStimulus(1'b0, '0, 5'b10000);
        applyStimulus(1'b0, '0, 5'b10000);
        checkOutput("steady last flit", bus.injectFlitOut, 64'h10B);

        // Multi-hot grant uses only the lowest set bit.
        applyStimulus(1'b1, 64'hBEEF, 5'b00000);
        applyStimulus(1'b0, '0, 5'b01010);
        checkOutput("multihot validOut", FW'(bus.injectValidOut), FW'(5'b00010));
        checkOutput("multihot flit", bus.injectFlitOut, 64'hBEEF);

        // Starvation: hold one flit without a grant.
        applyStimulus(1'b1, 64'h5A5A, 5'b00000);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 5'b00000);
        checkOutput("starve before threshold", FW'(bus.starve_flag), FW'(0));
        applyStimulus(1'b0, '0, 5'b00000);
`ifdef LOCAL_INJECT_STARVE_EN
        checkOutput("starve at threshold", FW'(bus.starve_flag), FW'(1));
`else
        checkOutput("starve disabled", FW'(bus.starve_flag), FW'(0));
`endif
        applyStimulus(1'b0, '0, 5'b00001);
        checkOutput("starve cleared", FW'(bus.starve_flag), FW'(0));
        checkOutput("starve flit", bus.injectFlitOut, 64'h5A5A);

        // Asynchronous reset mid-operation.
        applyStimulus(1'b1, 64'h77, 5'b00000);
        applyStimulus(1'b1, 64'h78, 5'b00010);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async pe_ready",   FW'(bus.pe_ready),       FW'(1));
        checkOutput("async inject_req", FW'(bus.inject_req),     FW'(0));
        checkOutput("async validOut",   FW'(bus.injectValidOut), FW'(0));
        checkOutput("async flitOut",    bus.injectFlitOut,       FW'(0));
        checkOutput("async starve",     FW'(bus.starve_flag),    FW'(0));
        bus.pe_valid         = 1'b0;
        bus.localInjectGrant = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        $display("[TB] random phase");
        for (int i = 0; i < 400; i++) begin
            logic [NUM_CH-1:0] g;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4)      g = '0;
            else if (sel < 8) g = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
            else              g = NUM_CH'($urandom);
            applyStimulus($urandom_range(0, 2) != 0, {$urandom, $urandom}, g);
        end

        applyStimulus(1'b0, '0, '0);
        checkEnable = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
